onchip_mem_stream_writer: RTL

Byte-stream-to-memory packer feeding the 208896-word × 32-bit on-chip RAM. It accepts 8-bit data with end-of-packet from an upstream byte source, such as a SpaceWire RX data path, and packs bytes little-endian into 32-bit words. Each word is written through an Avalon-MM write master into the RAM's s1 port, with byteenable marking a partial final word. Software configures a base word address and byte length, pulses start, and reads busy/done/error/count status.

---
 rtl/onchip_mem_stream_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_stream_writer.sv
// Byte-stream to on-chip RAM packer: little-endian packs 8-bit stream bytes
// into 32-bit words and writes them through an Avalon-MM write master.
module onchip_mem_stream_writer #(
  parameter int MEM_DEPTH = 208896,
  parameter int ADDR_W    = 18,
  parameter int LEN_W     = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_byte_len,
  input  logic [7:0]        sink_data,
  input  logic              sink_valid,
  input  logic              sink_eop,
  output logic              sink_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              stat_busy,
  output logic              stat_done,
  output logic [1:0]        stat_error,
  output logic [LEN_W-1:0]  stat_byte_count
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  // One past the last writable word, one bit wider so it is representable
  // alongside the incremented address.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

  state_t           state;
  logic [LEN_W-1:0] len;        // latched byte length, 0 = until eop
  logic [LEN_W-1:0] acc_cnt;    // bytes accepted from the stream so far
  logic [1:0]       lane;       // next byte lane in the packer
  logic             term;       // word in flight ends the transfer
  logic             abort_pend; // abort seen while a write is outstanding

  logic [ADDR_W:0]  addr_nxt;
  logic [LEN_W-1:0] acc_nxt;
  logic             base_ok;
  logic             accept;
  logic             hit;
  logic             wr_done;
  logic             abort_now;

  assign addr_nxt  = {1'b0, avm_address} + (ADDR_W+1)'(1);
  assign acc_nxt   = acc_cnt + LEN_W'(1);
  assign base_ok   = ({1'b0, cfg_base_addr} < DEPTH_X);
  assign accept    = sink_valid & sink_ready;
  // With a nonzero length the eop marker is ignored; the length alone ends it.
  assign hit       = (len != '0) ? (acc_nxt == len) : sink_eop;
  assign wr_done   = avm_write & ~avm_waitrequest;
  assign abort_now = cfg_abort | abort_pend;

  function automatic logic [LEN_W-1:0] popcnt(input logic [3:0] b);
    popcnt = LEN_W'(b[0]) + LEN_W'(b[1]) + LEN_W'(b[2]) + LEN_W'(b[3]);
  endfunction

  // Control FSM with registered handshake, Avalon and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      len             <= '0;
      acc_cnt         <= '0;
      lane            <= '0;
      term            <= 1'b0;
      abort_pend      <= 1'b0;
      sink_ready      <= 1'b0;
      avm_address     <= '0;
      avm_byteenable  <= '0;
      avm_chipselect  <= 1'b0;
      avm_write       <= 1'b0;
      avm_writedata   <= '0;
      stat_busy       <= 1'b0;
      stat_done       <= 1'b0;
      stat_error      <= '0;
      stat_byte_count <= '0;
    end else begin
      stat_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (base_ok) begin
              state           <= FILL;
              sink_ready      <= 1'b1;
              stat_busy       <= 1'b1;
              avm_address     <= cfg_base_addr;
              len             <= cfg_byte_len;
              acc_cnt         <= '0;
              lane            <= '0;
              term            <= 1'b0;
              abort_pend      <= 1'b0;
              avm_writedata   <= '0;
              avm_byteenable  <= '0;
              stat_error      <= '0;
              stat_byte_count <= '0;
            end else begin
              stat_error[0] <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cfg_abort) begin
            // Partial word is dropped; nothing reaches memory.
            state          <= IDLE;
            sink_ready     <= 1'b0;
            stat_busy      <= 1'b0;
            stat_error[1]  <= 1'b1;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            lane           <= '0;
          end else if (accept) begin
            avm_writedata[{lane, 3'b000} +: 8] <= sink_data;
            avm_byteenable[lane]               <= 1'b1;
            lane                               <= lane + 2'd1;
            acc_cnt                            <= acc_nxt;
            if (lane == 2'd3 || hit) begin
              state          <= WRITE;
              sink_ready     <= 1'b0;
              avm_write      <= 1'b1;
              avm_chipselect <= 1'b1;
              term           <= hit;
            end
          end
        end
        WRITE: begin
          if (cfg_abort) abort_pend <= 1'b1;
          if (wr_done) begin
            avm_write       <= 1'b0;
            avm_chipselect  <= 1'b0;
            stat_byte_count <= stat_byte_count + popcnt(avm_byteenable);
            avm_address     <= addr_nxt[ADDR_W-1:0];
            avm_writedata   <= '0;
            avm_byteenable  <= '0;
            lane            <= '0;
            if (abort_now) begin
              state         <= IDLE;
              stat_busy     <= 1'b0;
              stat_error[1] <= 1'b1;
            end else if (term) begin
              state     <= DONE;
              stat_done <= 1'b1;
            end else if (addr_nxt == DEPTH_X) begin
              state         <= IDLE;
              stat_busy     <= 1'b0;
              stat_error[0] <= 1'b1;
            end else begin
              state      <= FILL;
              sink_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          stat_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
